mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  - MEM stage of the 5-stage pipeline, between the EX/MEM latch and the MEM/WB latch.
//  - Runs each load/store against a variable-latency data memory using a req/ack handshake.
//  - Stalls the upstream pipeline until the access completes.
//  - Drives WB control, read data, ALU result and destination register into the MEM/WB latch.
//  - Inserts a bubble into MEM/WB while an access is in flight.
// PARAMETERS
//  DATA_W   32  data path width (read/write data, ALU result)
//  ADDR_W   32  data memory byte-address width
//  REG_W    5   register-file index width
//  TIMEOUT  16  max BUSY cycles to wait for mem_ack before aborting (>=2)
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  M_in           in   2       [1]=MemRead, [0]=MemWrite, from EX/MEM
//  WB_in          in   2       WB control from EX/MEM
//  ALUResult_in   in   DATA_W  ALU result; also the memory byte address
//  WriteData_in   in   DATA_W  store data
//  WriteReg_in    in   REG_W   destination register
//  mem_req        out  1       access request, held until ack
//  mem_we         out  1       1=write, 0=read; valid while mem_req
//  mem_addr       out  ADDR_W  word-aligned byte address; valid while mem_req
//  mem_wdata      out  DATA_W  store data; valid while mem_req && mem_we
//  mem_rdata      in   DATA_W  read data; sampled on the mem_ack cycle
//  mem_ack        in   1       one-cycle completion strobe
//  stall          out  1       1 = hold PC, IF/ID, ID/EX and EX/MEM
//  WB_out         out  2       to MEM/WB; 2'b00 = bubble
//  ReadData_out   out  DATA_W  to MEM/WB
//  ALUResult_out  out  DATA_W  to MEM/WB, pass-through
//  WriteReg_out   out  REG_W   to MEM/WB, pass-through
//  mem_err        out  1       sticky error flag (timeout or misalignment)
// BEHAVIOUR
//  - Definition: access = M_in[1] | M_in[0].
//  - MemWrite wins if both M_in bits are set; mem_err is set in that case.
//  - FSM states: IDLE, BUSY, DONE.
//    * IDLE, access with addr[1:0]==0: register addr, wdata and we; go to BUSY.
//    * IDLE, access with addr[1:0]!=0: no request; set mem_err; go to DONE with rdata_q=0.
//    * BUSY: mem_req=1. On mem_ack: capture mem_rdata into rdata_q; go to DONE.
//    * BUSY timeout: TIMEOUT cycles without ack -> drop req, rdata_q=0, set mem_err, go to DONE.
//    * DONE: stall=0 so EX/MEM advances; return to IDLE unconditionally next cycle.
//  - stall = (IDLE & access) | BUSY. Combinational from state and M_in.
//  - mem_req is a registered state decode. It never asserts in the same cycle as the IDLE decision.
//  - mem_ack outside BUSY is ignored.
//  - Minimum access: 3 cycles (IDLE, BUSY, DONE). Stall lasts 1 + BUSY cycles.
//  - WB_out = stall ? 2'b00 : WB_in.
//  - In DONE after a timeout or misalignment, WB_out = 2'b00 (load squashed).
//  - ReadData_out = rdata_q in DONE, 0 otherwise. Other outputs pass through combinationally.
//  - A non-memory instruction in IDLE passes straight through with zero added latency.
//  - Reset (at any point, including mid-BUSY): next state IDLE.
//    * mem_req, mem_we, mem_err, rdata_q, timeout counter all cleared to 0.
//    * mem_addr and mem_wdata cleared to 0.
//    * An in-flight memory ack after reset is ignored.
//  - mem_err clears only on rst.
// STRUCTURE
//  - Shared package (mem_pkg):
//    * state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
//    * M bit indices (M_READ=1, M_WRITE=0)
//    * WB_BUBBLE=2'b00
//  - Sub-module mem_timeout_ctr:
//    * clears on BUSY entry, counts while BUSY, asserts expire at TIMEOUT-1.
//  - Everything else lives in this module.
// TESTING
//  - Load, ack on 2nd BUSY cycle. M_in=2'b10, addr=0x100, rdata=0xCAFEF00D.
//    -> stall high 3 cycles, mem_req 2 cycles with we=0.
//    -> DONE: ReadData_out=0xCAFEF00D, WB_out=WB_in.
//  - Store, immediate ack. M_in=2'b01, addr=0x20, wdata=0x12345678.
//    -> mem_we=1, mem_addr=0x20 for 1 cycle; stall 2 cycles; ReadData_out=0 in DONE.
//  - Back-to-back loads at 0x0 and 0x4.
//    -> two distinct requests, separated by DONE and IDLE cycles.
//    -> second address sampled only after EX/MEM advances; no duplicate request.
//  - No ack, TIMEOUT=16.
//    -> mem_req drops after 16 BUSY cycles; mem_err=1; DONE with WB_out=0; FSM returns to IDLE.
//  - Misaligned load at addr=0x102.
//    -> no mem_req; mem_err=1; one stall cycle; WB_out=0 in DONE.
//  - rst on 3rd BUSY cycle, then a late mem_ack.
//    -> next cycle IDLE, all outputs 0, ack ignored.
//    -> a following ALU instruction passes with stall=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the MEM stage: FSM encoding, M-control bit positions, WB bubble.
package mem_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int M_READ  = 1;
   localparam int M_WRITE = 0;

   localparam logic [1:0] WB_BUBBLE = 2'b00;

   function automatic logic word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles of one memory access; expire marks the last cycle allowed to wait for ack.
module mem_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count,
   output logic expire
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = count && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack data-memory port, stalling upstream
// and bubbling MEM/WB until the access completes, times out, or is rejected as misaligned.
//
// state | meaning
// IDLE  | no access in flight; non-memory instructions pass straight through
// BUSY  | mem_req held, waiting for mem_ack or timeout
// DONE  | access finished; EX/MEM advances, result presented to MEM/WB
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int REG_W   = 5,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        M_in,
   input  logic [1:0]        WB_in,
   input  logic [DATA_W-1:0] ALUResult_in,
   input  logic [DATA_W-1:0] WriteData_in,
   input  logic [REG_W-1:0]  WriteReg_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic [1:0]        WB_out,
   output logic [DATA_W-1:0] ReadData_out,
   output logic [DATA_W-1:0] ALUResult_out,
   output logic [REG_W-1:0]  WriteReg_out,
   output logic              mem_err
);

   logic [1:0]        state;
   logic [DATA_W-1:0] rdata_q;
   logic              squash_q;
   logic              access;
   logic              aligned;
   logic              busy_entry;
   logic              expire;

   assign access     = M_in[M_READ] | M_in[M_WRITE];
   assign aligned    = word_aligned(ALUResult_in[1:0]);
   assign busy_entry = (state == ST_IDLE) && access && aligned;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (busy_entry),
      .count  (state == ST_BUSY),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata_q   <= '0;
         squash_q  <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (access) begin
                  rdata_q  <= '0;
                  squash_q <= !aligned;
                  // Conflicting read+write: the write is performed but flagged.
                  if (M_in[M_READ] && M_in[M_WRITE]) begin
                     mem_err <= 1'b1;
                  end
                  if (aligned) begin
                     mem_req   <= 1'b1;
                     mem_we    <= M_in[M_WRITE];
                     mem_addr  <= {ALUResult_in[ADDR_W-1:2], 2'b00};
                     mem_wdata <= WriteData_in;
                     state     <= ST_BUSY;
                  end else begin
                     mem_err <= 1'b1;
                     state   <= ST_DONE;
                  end
               end
            end
            ST_BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  rdata_q <= mem_we ? '0 : mem_rdata;
                  state   <= ST_DONE;
               end else if (expire) begin
                  mem_req  <= 1'b0;
                  rdata_q  <= '0;
                  squash_q <= 1'b1;
                  mem_err  <= 1'b1;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               squash_q <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign stall = ((state == ST_IDLE) && access) || (state == ST_BUSY);

   always_comb begin
      WB_out = WB_in;
      if (stall || ((state == ST_DONE) && squash_q)) begin
         WB_out = WB_BUBBLE;
      end
   end

   assign ReadData_out  = (state == ST_DONE) ? rdata_q : '0;
   assign ALUResult_out = ALUResult_in;
   assign WriteReg_out  = WriteReg_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: scoreboarded requests and MEM/WB results.
module tb_mem_access_stage;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int REG_W   = 5;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        M_in = '0;
   logic [1:0]        WB_in = '0;
   logic [DATA_W-1:0] ALUResult_in = '0;
   logic [DATA_W-1:0] WriteData_in = '0;
   logic [REG_W-1:0]  WriteReg_in = '0;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ack = 1'b0;
   logic              stall;
   logic [1:0]        WB_out;
   logic [DATA_W-1:0] ReadData_out;
   logic [DATA_W-1:0] ALUResult_out;
   logic [REG_W-1:0]  WriteReg_out;
   logic              mem_err;

   int checks = 0;
   int fails  = 0;
   logic exp_err = 1'b0;

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   typedef struct {
      logic [1:0]        wb;
      logic [DATA_W-1:0] rd;
      logic [DATA_W-1:0] alu;
      logic [REG_W-1:0]  wr;
   } res_t;

   req_t req_q[$];
   res_t res_q[$];

   mem_access_stage #(
      .DATA_W (DATA_W), .ADDR_W (ADDR_W), .REG_W (REG_W), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk), .rst (rst), .M_in (M_in), .WB_in (WB_in),
      .ALUResult_in (ALUResult_in), .WriteData_in (WriteData_in), .WriteReg_in (WriteReg_in),
      .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata), .mem_ack (mem_ack), .stall (stall), .WB_out (WB_out),
      .ReadData_out (ReadData_out), .ALUResult_out (ALUResult_out),
      .WriteReg_out (WriteReg_out), .mem_err (mem_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present one instruction in EX/MEM, act as the memory (ack after ack_at request cycles,
   // 0 = never), and hold the instruction until the stage releases stall.
   task automatic issue(input string name, input logic [1:0] m, input logic [1:0] wb,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wd,
                        input logic [REG_W-1:0] wr, input int ack_at,
                        input logic [DATA_W-1:0] rdata);
      logic acc, algn, tmo, squash, done, prev_req;
      int   busy, exp_stall, n_stall, n_req;
      logic [DATA_W-1:0] exp_rd;
      req_t r;
      res_t e;
      acc       = |m;
      algn      = (alu[1:0] == 2'b00);
      tmo       = acc && algn && !(ack_at >= 1 && ack_at <= TIMEOUT);
      busy      = (!acc || !algn) ? 0 : (tmo ? TIMEOUT : ack_at);
      exp_stall = acc ? 1 + busy : 0;
      squash    = acc && (!algn || tmo);
      exp_rd    = (acc && algn && !tmo && !m[0]) ? rdata : '0;
      if (acc && (!algn || tmo || m == 2'b11)) exp_err = 1'b1;
      if (acc && algn) req_q.push_back('{we: m[0], addr: {alu[ADDR_W-1:2], 2'b00}, wdata: wd});
      res_q.push_back('{wb: squash ? 2'b00 : wb, rd: exp_rd, alu: alu, wr: wr});

      M_in = m; WB_in = wb; ALUResult_in = alu; WriteData_in = wd; WriteReg_in = wr;
      n_stall = 0; n_req = 0; prev_req = 1'b0; done = 1'b0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         @(negedge clk);
         if (mem_req) begin
            n_req++;
            if (!prev_req) begin
               checks++;
               if (req_q.size() == 0) begin
                  fails++;
                  $display("FAIL %s unexpected_request: got addr=%h we=%b, expected none", name, mem_addr, mem_we);
               end else begin
                  r = req_q.pop_front();
                  if (mem_we !== r.we || mem_addr !== r.addr || (r.we && mem_wdata !== r.wdata)) begin
                     fails++;
                     $display("FAIL %s request: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                              name, mem_we, mem_addr, mem_wdata, r.we, r.addr, r.wdata);
                  end
               end
            end
         end
         prev_req = mem_req;
         if (stall) begin
            n_stall++;
         end else begin
            e = res_q.pop_front();
            checks++;
            if (WB_out !== e.wb || ReadData_out !== e.rd || ALUResult_out !== e.alu || WriteReg_out !== e.wr) begin
               fails++;
               $display("FAIL %s memwb: got wb=%b rd=%h alu=%h wr=%0d, expected wb=%b rd=%h alu=%h wr=%0d",
                        name, WB_out, ReadData_out, ALUResult_out, WriteReg_out, e.wb, e.rd, e.alu, e.wr);
            end
            done = 1'b1;
         end
         mem_ack   = mem_req && (n_req == ack_at);
         mem_rdata = mem_ack ? rdata : 32'hDEAD_BEEF;
      end
      checks++;
      if (!done) begin
         fails++;
         $display("FAIL %s completion: got stall still high after 60 cycles, expected release", name);
         res_q.delete();
      end
      checks++;
      if (n_stall != exp_stall) begin
         fails++;
         $display("FAIL %s stall_cycles: got %0d expected %0d", name, n_stall, exp_stall);
      end
      checks++;
      if (n_req != busy) begin
         fails++;
         $display("FAIL %s req_cycles: got %0d expected %0d", name, n_req, busy);
      end
      checks++;
      if (mem_err !== exp_err) begin
         fails++;
         $display("FAIL %s mem_err: got %b expected %b", name, mem_err, exp_err);
      end
      checks++;
      if (req_q.size() != 0) begin
         fails++;
         $display("FAIL %s missing_request: got %0d pending, expected 0", name, req_q.size());
         req_q.delete();
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({stall, mem_req, mem_we, mem_err} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
          WB_out !== 2'b00 || ReadData_out !== '0) begin
         fails++;
         $display("FAIL %s outputs: got stall=%b req=%b we=%b err=%b addr=%h wdata=%h wb=%b rd=%h, expected all 0",
                  name, stall, mem_req, mem_we, mem_err, mem_addr, mem_wdata, WB_out, ReadData_out);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      M_in = '0; WB_in = '0; ALUResult_in = '0; WriteData_in = '0; WriteReg_in = '0; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_err = 1'b0;
   endtask

   task automatic test_load();
      issue("load", 2'b10, 2'b11, 32'h100, 32'h0, 5'd4, 2, 32'hCAFE_F00D);
   endtask

   task automatic test_store();
      issue("store", 2'b01, 2'b00, 32'h20, 32'h1234_5678, 5'd0, 1, 32'h0);
   endtask

   task automatic test_back_to_back();
      issue("b2b_ld0", 2'b10, 2'b11, 32'h0, 32'h0, 5'd8, 1, 32'hA5A5_0001);
      issue("b2b_ld4", 2'b10, 2'b10, 32'h4, 32'h0, 5'd9, 3, 32'h5A5A_0002);
   endtask

   task automatic test_alu_pass();
      issue("alu_pass", 2'b00, 2'b10, 32'h0000_0103, 32'h77, 5'd12, 0, 32'h0);
   endtask

   task automatic test_timeout();
      issue("timeout", 2'b10, 2'b11, 32'h40, 32'h0, 5'd5, 0, 32'h0);
      issue("after_timeout", 2'b00, 2'b01, 32'h99, 32'h0, 5'd6, 0, 32'h0);
   endtask

   task automatic test_misaligned();
      issue("misaligned", 2'b10, 2'b11, 32'h102, 32'h0, 5'd7, 1, 32'h1111_2222);
   endtask

   task automatic test_reset_mid_busy();
      int n_req;
      req_t r;
      M_in = 2'b10; WB_in = 2'b11; ALUResult_in = 32'h200; WriteData_in = '0; WriteReg_in = 5'd3;
      n_req = 0;
      for (int cyc = 0; cyc < 10 && n_req < 3; cyc++) begin
         @(negedge clk);
         if (mem_req) begin
            n_req++;
            if (n_req == 1) begin
               r = '{we: 1'b0, addr: 32'h200, wdata: '0};
               req_q.push_back(r);
               r = req_q.pop_front();
               checks++;
               if (mem_addr !== r.addr || mem_we !== r.we) begin
                  fails++;
                  $display("FAIL rst_busy request: got addr=%h we=%b expected addr=%h we=%b", mem_addr, mem_we, r.addr, r.we);
               end
            end
         end
      end
      checks++;
      if (n_req != 3) begin
         fails++;
         $display("FAIL rst_busy reach_busy3: got %0d request cycles, expected 3", n_req);
      end
      rst = 1'b1;
      M_in = '0; WB_in = '0; ALUResult_in = '0; WriteData_in = '0; WriteReg_in = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_err = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 32'h1357_9BDF;
      @(negedge clk);
      check_all_zero("rst_busy_idle");
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      issue("alu_after_rst", 2'b00, 2'b11, 32'h55, 32'h0, 5'd7, 0, 32'h0);
   endtask

   task automatic test_both_bits();
      issue("both_bits", 2'b11, 2'b01, 32'h80, 32'hFEED_0001, 5'd2, 2, 32'h0);
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_back_to_back();
      test_alu_pass();
      test_timeout();
      test_reset();
      test_misaligned();
      test_reset_mid_busy();
      test_both_bits();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
